// File: rtl/mem_router_pkg.sv
// Shared constants and scoreboard types for the memory bank router.
package mem_router_pkg;

    localparam int unsigned NUM_BANKS_DEF = 3;
    localparam int unsigned SEL_W_DEF     = 2;
    localparam int unsigned DATA_W_DEF    = 32;
    localparam int unsigned CNT_W_DEF     = 8;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_ILLEGAL_SEL,
        ERR_WPROT
    } err_cause_t;

endpackage

// File: rtl/mem_bank_router_sat_counter.sv
// Saturating up-counter with synchronous clear; a clear coinciding with an
// increment leaves the count at 1 so the newest event is never lost.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= W'(inc);
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/mem_bank_router.sv
// Steers one data-memory port onto NUM_BANKS single-port banks, returns
// 1-cycle read data, and tracks illegal-select / write-protect errors.
module mem_bank_router
    import mem_router_pkg::*;
#(
    parameter int unsigned NUM_BANKS = NUM_BANKS_DEF,
    parameter int unsigned SEL_W     = SEL_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_valid,
    input  logic                        req_we,
    input  logic [SEL_W-1:0]            bank_sel,
    input  logic [NUM_BANKS-1:0]        wp_mask,
    output logic [NUM_BANKS-1:0]        bank_we,
    output logic [NUM_BANKS-1:0]        bank_re,
    input  logic [NUM_BANKS*DATA_W-1:0] bank_rdata,
    output logic [DATA_W-1:0]           rdata,
    output logic                        rdata_valid,
    output logic                        err_pulse,
    output logic                        err_sticky,
    output logic [CNT_W-1:0]            err_count,
    input  logic                        err_clear
);

    logic                 legal;
    logic                 wp_hit;
    logic                 active;
    logic                 err_now;
    logic [NUM_BANKS-1:0] sel_onehot;

    logic                 rd_pend;
    logic [SEL_W-1:0]     rd_bank;
    logic                 rd_ok;

    // Decode via a loop so an out-of-range select never indexes wp_mask.
    always_comb begin
        legal      = ({1'b0, bank_sel} < (SEL_W + 1)'(NUM_BANKS));
        wp_hit     = 1'b0;
        sel_onehot = '0;
        for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            if (bank_sel == SEL_W'(i)) begin
                sel_onehot[i] = 1'b1;
                wp_hit        = wp_mask[i];
            end
        end
        active  = req_valid & ~reset;
        bank_we = (active & req_we)  ? (sel_onehot & ~wp_mask) : '0;
        bank_re = (active & ~req_we) ? sel_onehot : '0;
        err_now = active & (~legal | (req_we & wp_hit));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend <= 1'b0;
            rd_bank <= '0;
            rd_ok   <= 1'b0;
        end else begin
            rd_pend <= req_valid & ~req_we;
            if (req_valid && !req_we) begin
                rd_bank <= bank_sel;
                rd_ok   <= legal;
            end
        end
    end

    // Gating with reset drops a read that was in flight when reset arrived.
    always_comb begin
        rdata_valid = rd_pend & ~reset;
        rdata       = '0;
        if (rdata_valid && rd_ok) begin
            for (int unsigned i = 0; i < NUM_BANKS; i++) begin
                if (rd_bank == SEL_W'(i)) begin
                    rdata = bank_rdata[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            err_pulse <= err_now;
            if (err_now) begin
                err_sticky <= 1'b1;
            end else if (err_clear) begin
                err_sticky <= 1'b0;
            end
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (err_clear),
        .inc   (err_now),
        .count (err_count)
    );

endmodule

// File: tb/tb_mem_bank_router.sv
// Directed plus random stimulus against an arithmetic reference model.
module tb_mem_bank_router;

    localparam int unsigned NB = 3;
    localparam int unsigned SW = 2;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_we = 1'b0;
    logic [SW-1:0]   bank_sel = '0;
    logic [NB-1:0]   wp_mask = '0;
    logic [NB-1:0]   bank_we;
    logic [NB-1:0]   bank_re;
    logic [NB*DW-1:0] bank_rdata;
    logic [DW-1:0]   rdata;
    logic            rdata_valid;
    logic            err_pulse;
    logic            err_sticky;
    logic [CW-1:0]   err_count;
    logic            err_clear = 1'b0;

    logic [DW-1:0]   bd [NB];
    assign bank_rdata = {bd[2], bd[1], bd[0]};

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_pend = 0;
    int m_bank = 0;
    bit m_ok = 0;
    bit m_pulse = 0;
    bit m_sticky = 0;
    int m_count = 0;
    bit rand_data = 0;

    always #5 clk = ~clk;

    mem_bank_router #(
        .NUM_BANKS (NB),
        .SEL_W     (SW),
        .DATA_W    (DW),
        .CNT_W     (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .bank_sel    (bank_sel),
        .wp_mask     (wp_mask),
        .bank_we     (bank_we),
        .bank_re     (bank_re),
        .bank_rdata  (bank_rdata),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .err_pulse   (err_pulse),
        .err_sticky  (err_sticky),
        .err_count   (err_count),
        .err_clear   (err_clear)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1: drive, check at posedge+2, advance model at the edge.
    task automatic cycle(input bit rst, input bit v, input bit w, input int sel,
                         input logic [NB-1:0] wp, input bit clr);
        bit legal, err;
        int exp_we, exp_re;
        reset = rst; req_valid = v; req_we = w; bank_sel = SW'(sel);
        wp_mask = wp; err_clear = clr;
        if (rand_data) for (int i = 0; i < NB; i++) bd[i] = $urandom;
        #1;
        legal  = (sel < NB);
        exp_we = (!rst && v && w && legal && !wp[sel]) ? (1 << sel) : 0;
        exp_re = (!rst && v && !w && legal) ? (1 << sel) : 0;
        chk("bank_we", 32'(bank_we), exp_we);
        chk("bank_re", 32'(bank_re), exp_re);
        chk("rdata_valid", 32'(rdata_valid), 32'(m_pend && !rst));
        chk("rdata", rdata, (m_pend && m_ok && !rst) ? bd[m_bank] : 32'h0);
        chk("err_pulse", 32'(err_pulse), 32'(m_pulse));
        chk("err_sticky", 32'(err_sticky), 32'(m_sticky));
        chk("err_count", 32'(err_count), m_count);
        @(posedge clk);
        if (rst) begin
            m_pend = 0; m_bank = 0; m_ok = 0;
            m_pulse = 0; m_sticky = 0; m_count = 0;
        end else begin
            err = v && (!legal || (w && wp[sel]));
            m_pulse = err;
            if (clr) m_count = err ? 1 : 0;
            else if (err) m_count = (m_count + 1 > 3) ? 3 : m_count + 1;
            if (err) m_sticky = 1;
            else if (clr) m_sticky = 0;
            m_pend = v && !w;
            if (m_pend) begin
                m_bank = sel;
                m_ok = legal;
            end
        end
        #1;
    endtask

    initial begin
        bd[0] = 32'h0000_00A0;
        bd[1] = 32'h0000_00B1;
        bd[2] = 32'h0000_00C2;
        @(posedge clk);
        #1;
        // reset state
        cycle(1, 0, 0, 0, 3'b000, 0);
        // write bank 1, unprotected
        cycle(0, 1, 1, 1, 3'b000, 0);
        // back-to-back reads bank 0 then bank 2
        cycle(0, 1, 0, 0, 3'b000, 0);
        cycle(0, 1, 0, 2, 3'b000, 0);
        cycle(0, 0, 0, 0, 3'b000, 0);
        // protected write
        cycle(0, 1, 1, 2, 3'b100, 0);
        cycle(0, 0, 0, 0, 3'b000, 0);
        // illegal read
        cycle(0, 1, 0, 3, 3'b000, 0);
        cycle(0, 0, 0, 0, 3'b000, 0);
        // saturation: five illegal requests
        for (int k = 0; k < 5; k++) cycle(0, 1, k % 2, 3, 3'b000, 0);
        // clear with simultaneous error, then clear alone
        cycle(0, 1, 1, 3, 3'b000, 1);
        cycle(0, 0, 0, 0, 3'b000, 1);
        cycle(0, 0, 0, 0, 3'b000, 0);
        // read then reset; request held during reset
        cycle(0, 1, 0, 1, 3'b000, 0);
        cycle(1, 1, 1, 3, 3'b111, 0);
        cycle(1, 1, 0, 3, 3'b000, 0);
        cycle(0, 0, 0, 0, 3'b000, 0);
        // random traffic
        rand_data = 1;
        for (int k = 0; k < 400; k++) begin
            cycle(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                  3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0));
        end
        cycle(0, 0, 0, 0, 3'b000, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
